// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan sequencer.
// Used by scan_next_idx and scan_sequencer.
package scan_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int SEL_W = 3;
   localparam int LINES = 8;

   // Prescaler width for a given step divisor; never narrower than one bit.
   function automatic int calc_cnt_w(input int div);
      if (div > 1) begin
         return $clog2(div);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/scan_next_idx.sv
// Combinational next-index search: nearest unmasked line in the scan direction,
// with a flag for crossing the 7/0 boundary. An all-zero mask gives plain modulo-8 stepping.
module scan_next_idx
   import scan_seq_pkg::*;
(
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_dir,
   input  logic [LINES-1:0] i_mask,
   output logic [SEL_W-1:0] o_next,
   output logic             o_wrap,
   output logic             o_none
);

   localparam int IW = SEL_W + 1;

   logic          w_found;
   logic          w_hit;
   logic          w_cross;
   logic [IW-1:0] w_sum;
   logic [SEL_W-1:0] w_cand;

   // Walk distances 1..8 and keep the first unmasked candidate.
   always_comb begin
      w_found = 1'b0;
      w_hit   = 1'b0;
      w_cross = 1'b0;
      w_sum   = {IW{1'b0}};
      w_cand  = {SEL_W{1'b0}};
      o_next  = i_sel;
      o_wrap  = 1'b0;
      for (int k = 1; k <= LINES; k++) begin
         w_sum   = i_dir ? ({1'b0, i_sel} + IW'(LINES - k)) : ({1'b0, i_sel} + IW'(k));
         w_cand  = w_sum[SEL_W-1:0];
         w_cross = i_dir ? ({1'b0, i_sel} < IW'(k)) : w_sum[SEL_W];
         w_hit   = ~w_found & ~i_mask[w_cand];
         o_next  = w_hit ? w_cand : o_next;
         o_wrap  = w_hit ? w_cross : o_wrap;
         w_found = w_found | w_hit;
      end
   end

   assign o_none = &i_mask;

endmodule

// File: rtl/scan_sequencer.sv
// Timed 0..7 select generator feeding a 3-to-8 decoder (select + enable).
// Optional line skipping is compiled in with SCAN_SEQ_SKIP_EN.
module scan_sequencer
   import scan_seq_pkg::*;
#(
   parameter int DIV   = 10,
   parameter int CNT_W = calc_cnt_w(DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic             dir,
   input  logic             load,
   input  logic [SEL_W-1:0] load_val,
`ifdef SCAN_SEQ_SKIP_EN
   input  logic [LINES-1:0] skip_mask,
`endif
   output logic [SEL_W-1:0] sel,
   output logic             sel_en,
   output logic             step,
   output logic             wrap,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   state_e           r_state,  w_state_nx;
   logic [SEL_W-1:0] r_sel,    w_sel_nx;
   logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
   logic             r_step,   w_step_nx;
   logic             r_wrap,   w_wrap_nx;
   logic             r_sel_en, w_sel_en_nx;
   logic             r_busy,   w_busy_nx;
   logic [SEL_W-1:0] w_next_idx;
   logic             w_next_wrap;
   logic             w_none;
   logic [LINES-1:0] w_mask;

`ifdef SCAN_SEQ_SKIP_EN
   assign w_mask = skip_mask;
`else
   assign w_mask = {LINES{1'b0}};
`endif

   scan_next_idx u_next (
      .i_sel  (r_sel),
      .i_dir  (dir),
      .i_mask (w_mask),
      .o_next (w_next_idx),
      .o_wrap (w_next_wrap),
      .o_none (w_none)
   );

   // State, select, prescaler and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_sel    <= {SEL_W{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
         r_step   <= 1'b0;
         r_wrap   <= 1'b0;
         r_sel_en <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_sel    <= w_sel_nx;
         r_cnt    <= w_cnt_nx;
         r_step   <= w_step_nx;
         r_wrap   <= w_wrap_nx;
         r_sel_en <= w_sel_en_nx;
         r_busy   <= w_busy_nx;
      end
   end

   // Next state with priority stop > load > start > hold > prescaler step.
   always_comb begin
      w_state_nx = r_state;
      w_sel_nx   = r_sel;
      w_cnt_nx   = r_cnt;
      w_step_nx  = 1'b0;
      w_wrap_nx  = 1'b0;
      if (stop) begin
         w_state_nx = ST_IDLE;
         w_sel_nx   = {SEL_W{1'b0}};
         w_cnt_nx   = {CNT_W{1'b0}};
      end else if (load) begin
         w_sel_nx = load_val;
         w_cnt_nx = {CNT_W{1'b0}};
         if ((r_state == ST_IDLE) && start) begin
            w_state_nx = ST_RUN;
         end else begin
            w_state_nx = r_state;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_state_nx = ST_RUN;
                  w_cnt_nx   = {CNT_W{1'b0}};
               end else begin
                  w_state_nx = ST_IDLE;
               end
            end
            // Leaving HOLD counts on the same edge so a hold costs exactly its cycle count.
            ST_RUN, ST_HOLD: begin
               if (hold) begin
                  w_state_nx = ST_HOLD;
               end else if (r_cnt == CNT_LAST) begin
                  w_state_nx = ST_RUN;
                  w_cnt_nx   = {CNT_W{1'b0}};
                  w_sel_nx   = w_none ? r_sel : w_next_idx;
                  w_step_nx  = ~w_none;
                  w_wrap_nx  = ~w_none & w_next_wrap;
               end else begin
                  w_state_nx = ST_RUN;
                  w_cnt_nx   = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
               w_sel_nx   = {SEL_W{1'b0}};
               w_cnt_nx   = {CNT_W{1'b0}};
            end
         endcase
      end
      w_busy_nx   = (w_state_nx != ST_IDLE);
      w_sel_en_nx = w_busy_nx & ~w_none;
   end

   assign sel    = r_sel;
   assign sel_en = r_sel_en;
   assign step   = r_step;
   assign wrap   = r_wrap;
   assign busy   = r_busy;

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized and directed bench for scan_sequencer (DIV=4 and DIV=1 instances, shared inputs)
// against a cycle-level behavioural model.
module tb_scan_sequencer;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HOLD = 2;

   logic       clk;
   logic       rst_n;
   logic       start, stop, hold, dir, load;
   logic [2:0] load_val;
   logic [7:0] mask_v;

   logic [2:0] sel4, sel1;
   logic       sel_en4, step4, wrap4, busy4;
   logic       sel_en1, step1, wrap1, busy1;

   int n_checks = 0;
   int n_errors = 0;

   int m_mode [2];
   int m_sel  [2];
   int m_cnt  [2];
   bit m_step [2];
   bit m_wrap [2];
   bit m_en   [2];
   bit m_busy [2];

   scan_sequencer #(.DIV(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold), .dir(dir),
      .load(load), .load_val(load_val),
`ifdef SCAN_SEQ_SKIP_EN
      .skip_mask(mask_v),
`endif
      .sel(sel4), .sel_en(sel_en4), .step(step4), .wrap(wrap4), .busy(busy4)
   );

   scan_sequencer #(.DIV(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold), .dir(dir),
      .load(load), .load_val(load_val),
`ifdef SCAN_SEQ_SKIP_EN
      .skip_mask(mask_v),
`endif
      .sel(sel1), .sel_en(sel_en1), .step(step1), .wrap(wrap1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Nearest unmasked index at distance 1..8 in the scan direction.
   task automatic model_next(input int s, input bit d, input logic [7:0] m,
                             output int n, output bit w, output bit ok);
      int c;
      ok = 1'b0; n = s; w = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         c = d ? ((s - k + 16) % 8) : ((s + k) % 8);
         if (!ok && (m[c] == 1'b0)) begin
            ok = 1'b1;
            n  = c;
            w  = d ? ((s - k) < 0) : ((s + k) > 7);
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = M_IDLE; m_sel[i] = 0; m_cnt[i] = 0;
         m_step[i] = 1'b0; m_wrap[i] = 1'b0; m_en[i] = 1'b0; m_busy[i] = 1'b0;
      end
   endtask

   // m_cnt holds counting cycles elapsed in the current step period.
   task automatic model_edge(input int i, input int div);
      int  n;
      bit  w, ok;
      logic [7:0] m;
      m = mask_v;
      m_step[i] = 1'b0;
      m_wrap[i] = 1'b0;
      if (stop) begin
         m_mode[i] = M_IDLE; m_sel[i] = 0; m_cnt[i] = 0;
      end else if (load) begin
         m_sel[i] = load_val; m_cnt[i] = 0;
         if (m_mode[i] == M_IDLE && start) m_mode[i] = M_RUN;
      end else if (m_mode[i] == M_IDLE) begin
         if (start) begin
            m_mode[i] = M_RUN; m_cnt[i] = 0;
         end
      end else if (hold) begin
         m_mode[i] = M_HOLD;
      end else begin
         m_mode[i] = M_RUN;
         m_cnt[i]  = m_cnt[i] + 1;
         if (m_cnt[i] == div) begin
            m_cnt[i] = 0;
            model_next(m_sel[i], dir, m, n, w, ok);
            if (ok) begin
               m_sel[i] = n; m_step[i] = 1'b1; m_wrap[i] = w;
            end
         end
      end
      m_busy[i] = (m_mode[i] != M_IDLE);
      m_en[i]   = m_busy[i] && (m != 8'hFF);
   endtask

   task automatic compare_all();
      check_eq("d4_sel",    sel4,    m_sel[0]);
      check_eq("d4_sel_en", sel_en4, m_en[0]);
      check_eq("d4_step",   step4,   m_step[0]);
      check_eq("d4_wrap",   wrap4,   m_wrap[0]);
      check_eq("d4_busy",   busy4,   m_busy[0]);
      check_eq("d1_sel",    sel1,    m_sel[1]);
      check_eq("d1_sel_en", sel_en1, m_en[1]);
      check_eq("d1_step",   step1,   m_step[1]);
      check_eq("d1_wrap",   wrap1,   m_wrap[1]);
      check_eq("d1_busy",   busy1,   m_busy[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(0, 4);
      model_edge(1, 1);
      #1;
      compare_all();
   endtask

   // Reset pulse placed between edges; outputs must clear before the next edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar_sel",    sel4,    32'd0);
      check_eq("ar_sel_en", sel_en4, 32'd0);
      check_eq("ar_busy",   busy4,   32'd0);
      check_eq("ar_step1",  step1,   32'd0);
      check_eq("ar_busy1",  busy1,   32'd0);
      model_reset();
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int first4, first1, gap, cnt;
      int exp_sel [3];
      int exp_wrap[3];
      bit found;

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; dir = 1'b0;
      load = 1'b0; load_val = 3'd0; mask_v = 8'h00;
      model_reset();
      #12;
      compare_all();
      rst_n = 1'b1;

      // Start pulse, count up: DIV=4 wraps 32 cycles in, DIV=1 wraps 8 cycles in.
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("start_en", sel_en4, 32'd1);
      check_eq("start_sel", sel4, 32'd0);
      first4 = -1; first1 = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (wrap4 && first4 < 0) first4 = k;
         if (wrap1 && first1 < 0) first1 = k;
      end
      check_eq("wrap_cyc4", first4, 32'd32);
      check_eq("wrap_cyc1", first1, 32'd8);

      // Hold 5 cycles at prescaler 2: gap between steps grows from 4 to 9.
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
         tick();
         found = step4;
      end
      check_eq("hold_sync", found, 32'd1);
      tick();
      tick();
      hold = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("hold_en", sel_en4, 32'd1);
      end
      hold = 1'b0;
      cnt = 0; found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         tick();
         cnt++;
         found = step4;
      end
      gap = 2 + 5 + cnt;
      check_eq("hold_gap", found ? gap : -1, 32'd9);

      // Load 5 while running, then stop+load together.
      load_val = 3'd5; load = 1'b1;
      tick();
      load = 1'b0;
      check_eq("ld_sel", sel4, 32'd5);
      stop = 1'b1; load = 1'b1; load_val = 3'd3;
      tick();
      stop = 1'b0; load = 1'b0;
      check_eq("sl_sel",  sel4,    32'd0);
      check_eq("sl_en",   sel_en4, 32'd0);
      check_eq("sl_step", step4,   32'd0);
      check_eq("sl_busy", busy4,   32'd0);

      // Down count on DIV=1 from a load-with-start of 2: 1, 0, 7 with wrap only on 7.
      dir = 1'b1; load_val = 3'd2; load = 1'b1; start = 1'b1;
      tick();
      load = 1'b0; start = 1'b0;
      check_eq("dn_sel0", sel1, 32'd2);
      check_eq("dn_step0", step1, 32'd0);
      exp_sel  = '{1, 0, 7};
      exp_wrap = '{0, 0, 1};
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("dn_sel", sel1, exp_sel[k]);
         check_eq("dn_wrap", wrap1, exp_wrap[k]);
      end

      // Asynchronous reset mid-scan.
      dir = 1'b0;
      tick();
      tick();
      async_reset();
      tick();
      check_eq("post_rst_busy", busy4, 32'd0);

`ifdef SCAN_SEQ_SKIP_EN
      // Skip build: mask 0x55 from sel 1 steps 3,5,7,1; all-masked disables and stops stepping.
      mask_v = 8'h55; load_val = 3'd1; load = 1'b1; start = 1'b1;
      tick();
      load = 1'b0; start = 1'b0;
      exp_sel  = '{3, 5, 7};
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("sk_sel", sel1, exp_sel[k]);
         check_eq("sk_wrap", wrap1, 32'd0);
      end
      tick();
      check_eq("sk_sel_w", sel1, 32'd1);
      check_eq("sk_wrap_w", wrap1, 32'd1);
      mask_v = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq("ff_en", sel_en1, 32'd0);
         check_eq("ff_step", step1, 32'd0);
      end
      mask_v = 8'h00;
`endif

      // Randomized traffic checked every cycle against the model.
      for (int i = 0; i < 600; i++) begin
         stop     = ($urandom_range(0, 29) == 0);
         load     = ($urandom_range(0, 19) == 0);
         load_val = 3'($urandom_range(0, 7));
         start    = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 9) == 0) hold = ~hold;
         if ($urandom_range(0, 15) == 0) dir = ~dir;
`ifdef SCAN_SEQ_SKIP_EN
         if ($urandom_range(0, 24) == 0) mask_v = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
`endif
         tick();
         if (i == 300) async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Timed index generator that sits directly upstream of the 3-to-8 line decoder. It produces the decoder's 3-bit select code and its enable. It steps the select up or down through 0..7 at a programmable rate, with start, stop, hold and load controls, so the decoder's one-hot output scans a bank of eight lines (LED column, keypad row, display digit).

## Interface
Parameters:
- DIV, default 10: clock cycles per step; legal range 1..65536.
- CNT_W, default $clog2(DIV) with a minimum of 1: prescaler width.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: reset. **Asynchronous, active-low.**
- start, input, 1: level; begins scanning from IDLE.
- stop, input, 1: level; returns to IDLE and clears sel.
- hold, input, 1: level; freezes stepping while RUN.
- dir, input, 1: 0 = count up, 1 = count down; sampled at each step.
- load, input, 1: one-cycle request to force sel to load_val.
- load_val, input, 3: value written by load.
- skip_mask, input, 8: only present with SCAN_SEQ_SKIP_EN; bit i = 1 excludes index i.
- sel, output, 3: select code to the decoder's `in`.
- sel_en, output, 1: decoder enable; 1 in RUN and HOLD.
- step, output, 1: one-cycle pulse on the cycle sel advances.
- wrap, output, 1: one-cycle pulse when a step crosses 7→0 (up) or 0→7 (down).
- busy, output, 1: 1 whenever state is not IDLE.

## Operation
- States: IDLE, RUN, HOLD.
- Reset values: state IDLE, sel 3'd0, prescaler 0, sel_en 0, step 0, wrap 0, busy 0.
- Per-edge priority: stop > load > start > hold > prescaler step.
- stop, from any state:
  - go to IDLE, sel ← 0, prescaler ← 0.
  - A load in the same cycle is ignored.
- load, from any state:
  - sel ← load_val, prescaler ← 0.
  - State is unchanged, except IDLE with start=1 goes to RUN.
  - No step or wrap pulse.
- IDLE to RUN: on start=1. Prescaler ← 0; sel is retained.
- RUN:
  - Prescaler counts 0..DIV-1.
  - At DIV-1 with hold=0: prescaler ← 0, sel ← next(sel, dir), step=1, wrap=1 if the step crosses a boundary.
  - hold=1 moves to HOLD with the prescaler frozen.
- HOLD:
  - sel and prescaler frozen; sel_en stays 1.
  - hold=0 returns to RUN, and counting resumes from the frozen prescaler value.
- start while in RUN or HOLD: no effect.
- next(sel, dir) without skip: modulo-8 increment (dir=0) or decrement (dir=1).
- step, wrap, busy and sel_en are registered outputs; no combinational path from inputs to outputs.

## Timing
- sel_en rises 1 cycle after start is sampled in IDLE, and falls 1 cycle after stop is sampled.
- First step occurs DIV cycles after RUN is entered; subsequent steps every DIV cycles while hold=0.
- DIV=1: sel steps on every RUN cycle.
- step and wrap are coincident with the new sel value and high for exactly one cycle.
- Cycles spent in HOLD extend the current step period by exactly their count.
- rst_n low mid-scan: all outputs reach their reset values immediately (asynchronously). The first active edge after release sees IDLE.
- dir changed mid-period: takes effect at the next step; no pulse is generated by the change itself.

## Configuration
- SCAN_SEQ_SKIP_EN defined:
  - skip_mask port exists.
  - next() returns the nearest unmasked index in direction dir, wrapping modulo 8.
  - wrap asserts if the search crosses the 7/0 boundary.
  - If every bit is masked: sel holds, sel_en = 0 while in RUN or HOLD, step = 0.
  - If the current sel is masked but others are not, the next step proceeds normally from sel.
  - A load to a masked index is accepted.
- SCAN_SEQ_SKIP_EN undefined: no skip_mask port; behaviour equals an all-zero mask.

## Structure
- Shared package scan_seq_pkg holds:
  - state enum (IDLE, RUN, HOLD);
  - SEL_W = 3 and LINES = 8;
  - a function computing CNT_W from DIV.
- One sub-module, scan_next_idx: combinational next-index and wrap computation from sel, dir and the optional mask. It is reused by both the normal and skip builds.
- Prescaler and FSM live in the top module.

## Test plan
- Reset and start, DIV=4, dir=0: start pulse → sel_en=1 next cycle; sel goes 0,1,2… every 4 cycles; wrap pulses on 7→0 at cycle 1+32.
- Down count, DIV=1, load_val=2 loaded in IDLE with start: sel sequence 2,1,0,7 → wrap on the 0→7 cycle only.
- Hold for 5 cycles mid-period at prescaler=2, DIV=4 → next step arrives 5 cycles late; sel_en stays 1 throughout.
- stop and load asserted in the same cycle while RUN with sel=5 → IDLE, sel=0, sel_en=0, no step pulse.
- Async reset asserted between clock edges while RUN → sel, sel_en and busy reach 0 before the next edge.
- SCAN_SEQ_SKIP_EN with mask 8'b0101_0101, dir=0 from sel=1 → sel goes 3,5,7,1 with wrap on 7→1. With mask 8'hFF → sel_en=0 and no step pulses.
